// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle pass/logic/add/sub/shift ops plus an iterative
// shift-add unsigned multiplier that takes WIDTH clocks after start.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             M,
    input  logic [3:0]       S,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] t,
    output logic             Cf,
    output logic             Zf,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       t_q, t_d;
    logic                   cf_q, cf_d;
    logic                   zf_q, zf_d;
    logic                   done_q, done_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [2*WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]       mplr_q, mplr_d;

    logic [WIDTH-1:0]       alu_t;
    logic                   alu_cf;
    logic [WIDTH:0]         sum;
    logic [WIDTH:0]         diff;
    logic [2*WIDTH-1:0]     acc_step;

    assign sum      = {1'b0, A} + {1'b0, B};
    assign diff     = {1'b0, B} - {1'b0, A};
    assign acc_step = acc_q + (mplr_q[0] ? mcand_q : '0);

    // Single-cycle result; MUL and unknown opcodes fall through to zero.
    always_comb begin
        alu_t  = '0;
        alu_cf = 1'b0;
        if (!M) begin
            if (S == 4'b1100) alu_t = A;
        end else begin
            case (S)
                4'b1001: begin alu_t = sum[WIDTH-1:0];  alu_cf = sum[WIDTH];  end
                4'b0110: begin alu_t = diff[WIDTH-1:0]; alu_cf = diff[WIDTH]; end
                4'b1011: alu_t = A & B;
                4'b0101: alu_t = ~B;
                4'b1010,
                4'b0100: alu_t = B;
                4'b1100: alu_t = A;
                4'b0011: begin alu_t = {A[WIDTH-2:0], 1'b0}; alu_cf = A[WIDTH-1]; end
                4'b0111: begin alu_t = {1'b0, A[WIDTH-1:1]}; alu_cf = A[0];       end
                default: alu_t = '0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        cf_d    = cf_q;
        zf_d    = zf_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (M && S == 4'b0010) begin
                        state_d = MUL;
                        cnt_d   = '0;
                        acc_d   = '0;
                        mcand_d = {{WIDTH{1'b0}}, A};
                        mplr_d  = B;
                    end else begin
                        t_d    = alu_t;
                        cf_d   = alu_cf;
                        zf_d   = M && (alu_t == '0);
                        done_d = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d   = acc_step;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    t_d     = acc_step[WIDTH-1:0];
                    cf_d    = |acc_step[2*WIDTH-1:WIDTH];
                    zf_d    = (acc_step[WIDTH-1:0] == '0);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            cf_q    <= 1'b0;
            zf_q    <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            cf_q    <= cf_d;
            zf_q    <= zf_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
        end
    end

    assign t    = t_q;
    assign Cf   = cf_q;
    assign Zf   = zf_q;
    assign done = done_q;
    assign busy = (state_q == MUL);

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8: stimulus pushes expected results,
// a negedge monitor pops one entry per done pulse.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       M = 1'b0;
    logic [3:0] S = 4'b0000;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;
    logic [7:0] t;
    logic       Cf, Zf, busy, done;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] t;
        logic       cf;
        logic       zf;
    } exp_t;

    exp_t exp_q[$];

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .M(M), .S(S),
        .A(A), .B(B), .t(t), .Cf(Cf), .Zf(Zf), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done actual t=%0h Cf=%0b Zf=%0b expected no result", t, Cf, Zf);
            end else begin
                e = exp_q.pop_front();
                if ({t, Cf, Zf} !== {e.t, e.cf, e.zf}) begin
                    failures++;
                    $display("FAIL result actual t=%0h Cf=%0b Zf=%0b expected t=%0h Cf=%0b Zf=%0b",
                             t, Cf, Zf, e.t, e.cf, e.zf);
                end
            end
        end
    end

    task automatic op(input logic m, input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] et, input logic ecf, input logic ezf);
        exp_t e;
        @(negedge clk);
        M = m; S = s; A = a; B = b; start = 1'b1;
        e.t = et; e.cf = ecf; e.zf = ezf;
        exp_q.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Multiply, pulsing start with scrambled operands while busy.
    task automatic mul_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] et, input logic ecf, input logic ezf);
        op(1'b1, 4'b0010, a, b, et, ecf, ezf);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("mul_busy", {31'b0, busy}, 32'd1);
            chk("mul_no_done", {31'b0, done}, 32'd0);
            M = 1'b1; S = 4'b1001; A = 8'hFF; B = 8'h01; start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        @(negedge clk);
        chk("mul_busy_cleared", {31'b0, busy}, 32'd0);
        chk("mul_done", {31'b0, done}, 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_t", {24'b0, t}, 32'h0);
        chk("reset_flags", {28'b0, Cf, Zf, busy, done}, 32'h0);

        op(1'b1, 4'b1001, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
        @(negedge clk);
        chk("add_busy", {31'b0, busy}, 32'd0);
        op(1'b1, 4'b1001, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0);
        op(1'b1, 4'b0110, 8'h05, 8'h03, 8'hFE, 1'b1, 1'b0);
        op(1'b1, 4'b0110, 8'h03, 8'h03, 8'h00, 1'b0, 1'b1);
        op(1'b0, 4'b1100, 8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0);
        op(1'b0, 4'b1001, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0);
        op(1'b0, 4'b1100, 8'h00, 8'h77, 8'h00, 1'b0, 1'b0);
        op(1'b1, 4'b0011, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0);
        op(1'b1, 4'b0111, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1);
        op(1'b1, 4'b1111, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1);
        op(1'b1, 4'b1011, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
        op(1'b1, 4'b0101, 8'h00, 8'h0F, 8'hF0, 1'b0, 1'b0);
        op(1'b1, 4'b1010, 8'h11, 8'hA5, 8'hA5, 1'b0, 1'b0);
        op(1'b1, 4'b0100, 8'h11, 8'h00, 8'h00, 1'b0, 1'b1);
        op(1'b1, 4'b1100, 8'h7E, 8'h00, 8'h7E, 1'b0, 1'b0);

        mul_op(8'h10, 8'h11, 8'h10, 1'b1, 1'b0);
        mul_op(8'h0C, 8'h0A, 8'h78, 1'b0, 1'b0);
        mul_op(8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0);
        mul_op(8'h00, 8'h5B, 8'h00, 1'b0, 1'b1);
        op(1'b1, 4'b1001, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);

        // Abort a multiply four cycles in; reset wins over a simultaneous start.
        @(negedge clk);
        M = 1'b1; S = 4'b0010; A = 8'h10; B = 8'h11; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; start = 1'b1; S = 4'b1001; A = 8'h02; B = 8'h03;
        @(posedge clk);
        #1 rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("abort_t", {24'b0, t}, 32'h0);
        chk("abort_flags", {28'b0, Cf, Zf, busy, done}, 32'h0);
        repeat (10) @(negedge clk);
        chk("abort_idle_busy", {31'b0, busy}, 32'd0);
        op(1'b1, 4'b1001, 8'h02, 8'h03, 8'h05, 1'b0, 1'b0);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("pending_results", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
